// File: rtl/cga_text_if.sv
// Memory bus between the text-mode pixel source and its two synchronous
// memories: the text RAM holding {attribute, char} words and the font ROM
// holding one glyph row per address.
//   tram_addr_o  12  text RAM word address (row*COLS + col)
//   tram_data_i  16  text RAM read data, [15:8] attribute, [7:0] char code
//   font_addr_o  12  font ROM address {char, glyph line}
//   font_data_i   8  glyph row, bit 7 is the leftmost pixel
// The master modport is the pixel source; the slave modport is the memory side.
interface cga_text_if;
  logic [11:0] tram_addr_o;
  logic [15:0] tram_data_i;
  logic [11:0] font_addr_o;
  logic [7:0]  font_data_i;

  modport master (
    output tram_addr_o,
    output font_addr_o,
    input  tram_data_i,
    input  font_data_i
  );

  modport slave (
    input  tram_addr_o,
    input  font_addr_o,
    output tram_data_i,
    output font_data_i
  );
endinterface

// File: rtl/cga_text.sv
// Text-mode pixel source for the CGA colour stage.
// A four-stage pipeline turns the raster position into a text RAM fetch, a
// font ROM fetch and finally a serialised glyph bit. color_o leaves one stage
// ahead of on_o because the downstream colour stage registers the attribute
// once and uses on_o unregistered, so both line up there.
// Ports:
//   clk_i      pixel clock
//   rstn_i     asynchronous active-low reset
//   x_i, y_i   raster position (10 bits each), active_i visible-area flag
//   vsync_i    vertical sync, only used by the blink option
//   mem        text RAM / font ROM bus (cga_text_if.master)
//   color_o    attribute byte, background [7:4] / foreground [3:0]
//   on_o       foreground pixel select
// Optional feature: define CGA_TEXT_BLINK_EN to make attribute bit 7 a blink
// flag driven by a 5-bit vsync frame counter instead of bright background.
module cga_text #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic       active_i,
  input  logic       vsync_i,
  cga_text_if.master mem,
  output logic [7:0] color_o,
  output logic       on_o
);

  // The whole screen must fit in the 12-bit text RAM address space.
  if (COLS * ROWS > 4096) begin : g_size_chk
    $error("cga_text: COLS*ROWS exceeds the 12-bit text RAM address space");
  end

  // S1: raster position split into cell coordinates and in-cell offsets.
  logic [6:0] col_s1;
  logic [5:0] row_s1;
  logic [2:0] px_s1;
  logic [3:0] line_s1;
  logic       act_s1;
  // S2/S3: offsets travel alongside the memory fetches.
  logic [2:0] px_s2, px_s3;
  logic [3:0] line_s2;
  logic       act_s2, act_s3;
  logic       blank_s3;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_s1  <= '0;
      row_s1  <= '0;
      px_s1   <= '0;
      line_s1 <= '0;
      act_s1  <= 1'b0;
      px_s2   <= '0;
      line_s2 <= '0;
      act_s2  <= 1'b0;
      px_s3   <= '0;
      act_s3  <= 1'b0;
    end else begin
      col_s1  <= x_i[9:3];
      row_s1  <= y_i[9:4];
      px_s1   <= x_i[2:0];
      line_s1 <= y_i[3:0];
      act_s1  <= active_i;
      px_s2   <= px_s1;
      line_s2 <= line_s1;
      act_s2  <= act_s1;
      px_s3   <= px_s2;
      act_s3  <= act_s2;
    end
  end

  // Off-screen col/row are not clamped: the address simply wraps in 12 bits
  // and the fetched data is masked by act further down the pipe.
  assign mem.tram_addr_o = 12'(row_s1) * 12'(COLS) + 12'(col_s1);

  // The char code comes straight from RAM, which is not reset, so the ROM
  // address is held at zero while reset is asserted.
  assign mem.font_addr_o = rstn_i ? {mem.tram_data_i[7:0], line_s2} : '0;

  // S3: attribute capture, S4: glyph bit selection.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      color_o <= '0;
      on_o    <= 1'b0;
    end else begin
`ifdef CGA_TEXT_BLINK_EN
      color_o <= act_s2 ? {1'b0, mem.tram_data_i[14:8]} : '0;
`else
      color_o <= act_s2 ? mem.tram_data_i[15:8] : '0;
`endif
      // Bit 7 is the leftmost pixel, so the index is 7 - px, i.e. ~px.
      on_o <= act_s3 & mem.font_data_i[~px_s3] & ~blank_s3;
    end
  end

`ifdef CGA_TEXT_BLINK_EN
  logic       vsync_q;
  logic [4:0] frame_cnt;
  logic       attr7_s3;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vsync_q   <= 1'b0;
      frame_cnt <= '0;
      attr7_s3  <= 1'b0;
    end else begin
      vsync_q  <= vsync_i;
      attr7_s3 <= mem.tram_data_i[15];
      if (vsync_i && !vsync_q) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  // Counter MSB toggles every 16 frames; blinking cells lose their
  // foreground during the upper half of the 32-frame cycle.
  assign blank_s3 = attr7_s3 & frame_cnt[4];
`else
  logic unused_vsync;
  assign unused_vsync = vsync_i;
  assign blank_s3     = 1'b0;
`endif

endmodule

// File: tb/tb_cga_text.sv
module tb_cga_text;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0;
  logic [9:0] x_i = '0;
  logic [9:0] y_i = '0;
  logic       active_i = 1'b0;
  logic       vsync_i = 1'b0;
  logic [7:0] color_o;
  logic       on_o;

  cga_text_if bus ();

  cga_text #(.COLS(80), .ROWS(30)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .x_i      (x_i),
    .y_i      (y_i),
    .active_i (active_i),
    .vsync_i  (vsync_i),
    .mem      (bus.master),
    .color_o  (color_o),
    .on_o     (on_o)
  );

  always #5 clk = ~clk;

  // Memories with one-cycle synchronous read.
  logic [15:0] tram [4096];
  logic [7:0]  font [4096];
  logic [15:0] tram_q = '0;
  logic [7:0]  font_q = '0;
  always @(posedge clk) begin
    tram_q <= tram[bus.tram_addr_o];
    font_q <= font[bus.font_addr_o];
  end
  assign bus.tram_data_i = tram_q;
  assign bus.font_data_i = font_q;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // History of positions sampled at the last four clock edges; a reset
  // empties the pipe, which looks exactly like position (0,0) inactive.
  logic [9:0] hx [4];
  logic [9:0] hy [4];
  logic       ha [4];
  logic [4:0] frames;
  logic       vs_prev;
  logic       cur_ph;
  int         edges_since_rst;

  initial begin
    forever begin
      @(posedge clk or negedge rstn_i);
      if (!rstn_i) begin
        for (int i = 0; i < 4; i++) begin
          hx[i] = '0; hy[i] = '0; ha[i] = 1'b0;
        end
        frames = '0; vs_prev = 1'b0; cur_ph = 1'b0; edges_since_rst = 0;
      end else begin
        for (int i = 3; i > 0; i--) begin
          hx[i] = hx[i-1]; hy[i] = hy[i-1]; ha[i] = ha[i-1];
        end
        hx[0] = x_i; hy[0] = y_i; ha[0] = active_i;
        cur_ph = frames[4];
        if (vsync_i && !vs_prev) frames = frames + 5'd1;
        vs_prev = vsync_i;
        edges_since_rst++;
      end
    end
  end

  function automatic logic [11:0] taddr(input logic [9:0] x, input logic [9:0] y);
    int unsigned xi, yi, a;
    xi = x; yi = y;
    a = (yi / 16) * 80 + xi / 8;
    return a[11:0];
  endfunction

  function automatic logic [7:0] exp_color(input logic [9:0] x, input logic [9:0] y, input logic a);
    logic [15:0] w;
    logic [7:0]  at;
    w  = tram[taddr(x, y)];
    at = w[15:8];
`ifdef CGA_TEXT_BLINK_EN
    at[7] = 1'b0;
`endif
    return a ? at : 8'h00;
  endfunction

  function automatic logic exp_on(input logic [9:0] x, input logic [9:0] y, input logic a, input logic ph);
    logic [15:0] w;
    logic [7:0]  g;
    logic [3:0]  ln;
    logic        blank;
    int unsigned bitpos;
    w  = tram[taddr(x, y)];
    ln = y[3:0];
    g  = font[{w[7:0], ln}];
    bitpos = 7 - int'(x[2:0]);
    blank = 1'b0;
`ifdef CGA_TEXT_BLINK_EN
    blank = w[15] & ph;
`endif
    return a & g[bitpos] & ~blank;
  endfunction

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        chk("rst_tram_addr", 16'(bus.tram_addr_o), 16'h0);
        chk("rst_font_addr", 16'(bus.font_addr_o), 16'h0);
        chk("rst_color", 16'(color_o), 16'h0);
        chk("rst_on", 16'(on_o), 16'h0);
      end else begin
        chk("tram_addr", 16'(bus.tram_addr_o), 16'(taddr(hx[0], hy[0])));
        if (edges_since_rst >= 1)
          chk("font_addr", 16'(bus.font_addr_o),
              16'({tram[taddr(hx[1], hy[1])][7:0], hy[1][3:0]}));
        chk("color", 16'(color_o), 16'(exp_color(hx[2], hy[2], ha[2])));
        chk("on", 16'(on_o), 16'(exp_on(hx[3], hy[3], ha[3], cur_ph)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int unsigned x, input int unsigned y, input logic a);
    x_i = 10'(x); y_i = 10'(y); active_i = a;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic hold_reset;
    @(posedge clk); #1;
    rstn_i = 1'b0;
    drive(0, 0, 1'b0);
    vsync_i = 1'b0;
  endtask

  task automatic release_reset;
    tick; tick;
    rstn_i = 1'b1;
  endtask

  logic [0:7] on_seq;
  logic [7:0] exp_c;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tram[i] = '0; font[i] = '0;
    end
    on_seq = 8'b1100_0011;

    // Cell (0,0) and (1,0): char 41h attr 1Eh, glyph line 0 = C3h.
    hold_reset;
    tram[0] = 16'h1E41; tram[1] = 16'h1E41; font[12'h410] = 8'hC3;
    release_reset;
    drive(0, 0, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      drive((n < 8) ? n : 8, 0, 1'b1);
      @(negedge clk);
      if (n == 1) chk("lit_tram_addr", 16'(bus.tram_addr_o), 16'h000);
      if (n == 2) chk("lit_font_addr", 16'(bus.font_addr_o), 16'h410);
      if (n == 3) chk("lit_color", 16'(color_o), 16'h1E);
      if (n >= 4 && n <= 11) chk("lit_on_seq", 16'(on_o), 16'(on_seq[n-4]));
    end

    // Short reset pulse between edges while cell (1,0) is being shown.
    @(posedge clk); #2;
    rstn_i = 1'b0;
    #1;
    chk("async_tram_addr", 16'(bus.tram_addr_o), 16'h0);
    chk("async_font_addr", 16'(bus.font_addr_o), 16'h0);
    chk("async_color", 16'(color_o), 16'h0);
    chk("async_on", 16'(on_o), 16'h0);
    #1;
    rstn_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_on", 16'(on_o), (k == 4) ? 16'h1 : 16'h0);
      if (k == 2) chk("post_rst_color0", 16'(color_o), 16'h00);
      if (k == 3) chk("post_rst_color", 16'(color_o), 16'h1E);
    end

    // Bottom-right visible pixel.
    @(posedge clk); #1;
    drive(639, 479, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("corner_tram_addr", 16'(bus.tram_addr_o), 16'h95F);
    @(posedge clk);
    @(negedge clk);
    chk("corner_line", 16'(bus.font_addr_o[3:0]), 16'hF);

    // active_i drop with an all-ones attribute and glyph.
    hold_reset;
    tram[0] = 16'hFF00; font[12'h000] = 8'hFF;
    release_reset;
    drive(0, 0, 1'b1);
    repeat (6) tick;
    drive(0, 0, 1'b0);
`ifdef CGA_TEXT_BLINK_EN
    exp_c = 8'h7F;
`else
    exp_c = 8'hFF;
`endif
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) chk("inact_color_prev", 16'(color_o), 16'(exp_c));
      if (k == 3) begin
        chk("inact_color", 16'(color_o), 16'h00);
        chk("inact_on_prev", 16'(on_o), 16'h1);
      end
      if (k == 4) chk("inact_on", 16'(on_o), 16'h0);
    end

    // Blink sweep over 34 frames: attr 8Fh, glyph all ones.
    hold_reset;
    tram[0] = 16'h8F00; font[12'h000] = 8'hFF;
    release_reset;
    drive(0, 0, 1'b1);
    for (int f = 0; f < 34; f++) begin
      repeat (6) tick;
      @(negedge clk);
`ifdef CGA_TEXT_BLINK_EN
      chk("blink_color", 16'(color_o), 16'h0F);
      chk("blink_on", 16'(on_o), ((f % 32) < 16) ? 16'h1 : 16'h0);
`else
      chk("blink_color", 16'(color_o), 16'h8F);
      chk("blink_on", 16'(on_o), 16'h1);
`endif
      @(posedge clk); #1;
      vsync_i = 1'b1;
      tick; tick;
      vsync_i = 1'b0;
    end

    // Random memory contents and random positions, checked by the model.
    hold_reset;
    for (int i = 0; i < 4096; i++) begin
      tram[i] = 16'($urandom);
      font[i] = 8'($urandom);
    end
    release_reset;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1023), $urandom_range(0, 1023), ($urandom_range(0, 9) < 8));
      vsync_i = ($urandom_range(0, 49) == 0);
      tick;
    end
    vsync_i = 1'b0;
    // One raster line including blanking.
    for (int x = 0; x < 800; x++) begin
      drive(x, 237, (x < 640));
      tick;
    end
    repeat (6) tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
